// File: rtl/uart_tx_sched_if.sv
// ---------------------------------------------------------------------------
// uart_tx_sched_if
// Handshake bundle between the two byte sources, the scheduler and the
// UART transmitter core.
//   s0_valid/s0_data/s0_last/s0_ready : byte stream from source 0
//   s1_valid/s1_data/s1_last/s1_ready : byte stream from source 1
//   tx_start/tx_data                  : start pulse and byte to the Tx core
//   tx_busy                           : Tx core is shifting a frame
// modport master : the scheduler (accepts bytes, drives the transmitter)
// modport slave  : the surroundings (sources and Tx core)
// ---------------------------------------------------------------------------
interface uart_tx_sched_if;
  logic       s0_valid;
  logic [7:0] s0_data;
  logic       s0_last;
  logic       s0_ready;
  logic       s1_valid;
  logic [7:0] s1_data;
  logic       s1_last;
  logic       s1_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;

  modport master (
    input  s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, tx_busy,
    output s0_ready, s1_ready, tx_start, tx_data
  );

  modport slave (
    output s0_valid, s0_data, s0_last, s1_valid, s1_data, s1_last, tx_busy,
    input  s0_ready, s1_ready, tx_start, tx_data
  );
endinterface

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
// Round-robin scheduler sharing one UART transmitter between two byte
// sources. A byte is accepted over valid/ready, handed to the Tx core with a
// one-cycle start pulse, and the scheduler follows tx_busy until the frame
// is done, then waits GAP_CYCLES idle cycles. A byte without last keeps the
// grant locked to its source so multi-byte packets are never interleaved.
// Ports:
//   clk         : system clock
//   rst         : synchronous reset, active-high
//   en          : 0 blocks new grants; an in-flight byte still completes
//   bus         : source handshakes and Tx core signals (master side)
//   grant       : one-hot current owner, 00 when idle and unlocked
//   err_timeout : sticky, tx_busy never rose within ACK_TIMEOUT cycles
// ---------------------------------------------------------------------------
module uart_tx_sched #(
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  uart_tx_sched_if.master   bus,
  output logic [1:0]        grant,
  output logic              err_timeout
);

  localparam int TW = $clog2((ACK_TIMEOUT > 2) ? ACK_TIMEOUT : 2);
  localparam int GW = $clog2((GAP_CYCLES > 2) ? GAP_CYCLES : 2);
  localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_WAIT_ACK  = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_GAP       = 3'd4;

  logic [2:0]    r_state;
  logic [7:0]    r_tx_data;
  logic [1:0]    r_grant;
  logic          r_owner;     // source of the byte in flight / locked owner
  logic          r_rr;        // source favoured when both are valid
  logic          r_lock;      // packet open: only r_owner may be granted
  logic          r_err;
  logic [TW-1:0] r_timer;
  logic [GW-1:0] r_gap;

  logic       w_sel;
  logic       w_sel_valid;
  logic       w_take;
  logic [7:0] w_sel_data;
  logic       w_sel_last;

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sel       = 1'b0;
    w_sel_valid = 1'b0;
    if (r_lock) begin
      w_sel       = r_owner;
      w_sel_valid = r_owner ? bus.s1_valid : bus.s0_valid;
    end else if (bus.s0_valid && bus.s1_valid) begin
      w_sel       = r_rr;
      w_sel_valid = 1'b1;
    end else if (bus.s0_valid) begin
      w_sel       = 1'b0;
      w_sel_valid = 1'b1;
    end else if (bus.s1_valid) begin
      w_sel       = 1'b1;
      w_sel_valid = 1'b1;
    end
  end

  assign w_take     = (r_state == S_IDLE) && en && w_sel_valid;
  assign w_sel_data = w_sel ? bus.s1_data : bus.s0_data;
  assign w_sel_last = w_sel ? bus.s1_last : bus.s0_last;

  // Single w_sel makes the two readies mutually exclusive by construction.
  assign bus.s0_ready = w_take && !w_sel;
  assign bus.s1_ready = w_take &&  w_sel;
  assign bus.tx_start = (r_state == S_START);
  assign bus.tx_data  = r_tx_data;
  assign grant        = r_grant;
  assign err_timeout  = r_err;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_tx_data <= '0;
      r_grant   <= '0;
      r_owner   <= 1'b0;
      r_rr      <= 1'b0;
      r_lock    <= 1'b0;
      r_err     <= 1'b0;
      r_timer   <= '0;
      r_gap     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_tx_data <= w_sel_data;
            r_owner   <= w_sel;
            r_grant   <= w_sel ? 2'b10 : 2'b01;
            r_lock    <= !w_sel_last;
            // Pointer only moves once a packet is closed.
            if (w_sel_last) r_rr <= !w_sel;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (bus.tx_busy) begin
            r_state <= S_WAIT_DONE;
          end else if (r_timer == TIMER_LAST) begin
            // Transmitter never acknowledged: drop the byte and the packet.
            r_err   <= 1'b1;
            r_lock  <= 1'b0;
            r_rr    <= !r_owner;
            r_grant <= '0;
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            r_gap <= '0;
            if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
              if (!r_lock) r_grant <= '0;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            r_state <= S_IDLE;
            if (!r_lock) r_grant <= '0;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_sched
// Self-checking bench for uart_tx_sched: an arbitration vector table,
// hand-written sequences for latency, packet locking, timeout, enable and
// reset, and a randomized run against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_uart_tx_sched;
  localparam int GAP   = 4;
  localparam int ACKTO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] grant;
  logic       err;

  always #5 clk = ~clk;

  uart_tx_sched_if bus ();

  uart_tx_sched #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(ACKTO)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .bus         (bus),
    .grant       (grant),
    .err_timeout (err)
  );

  int n_vec    = 0;
  int n_err    = 0;
  int both_cnt = 0;
  int busy_len = 0;
  int busy_cnt = 0;

  typedef struct {
    logic       en;
    logic       v0;
    logic       v1;
    logic [1:0] rdy;   // {s1_ready, s0_ready}
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; Tx core model raises busy for busy_len cycles after
  // a start pulse (busy_len 0 = core never acknowledges).
  task automatic cyc();
    logic st;
    st = bus.tx_start;
    @(posedge clk);
    #1;
    if (st && busy_len > 0) begin
      bus.tx_busy = 1'b1;
      busy_cnt    = busy_len;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) bus.tx_busy = 1'b0;
    end
  endtask

  task automatic smp();
    #1;
    if (bus.s0_ready && bus.s1_ready) both_cnt++;
  endtask

  task automatic clear_src();
    bus.s0_valid = 1'b0; bus.s0_data = '0; bus.s0_last = 1'b0;
    bus.s1_valid = 1'b0; bus.s1_data = '0; bus.s1_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    clear_src();
    cyc();
    cyc();
    bus.tx_busy = 1'b0;
    busy_cnt    = 0;
    rst         = 1'b0;
  endtask

  task automatic wait_any(input int budget, output int k);
    k = 0;
    while (!(bus.s0_ready || bus.s1_ready) && k < budget) begin
      cyc();
      smp();
      k++;
    end
    check("wait_ready_in_budget", 32'(k < budget), 1);
  endtask

  // Randomized-run state
  int         now, m_ready_at, m_start_at, m_err_at, bl, k, cnt;
  logic       m_lock, m_owner, m_rr, m_rel, m_err, sel;
  logic [1:0] m_grant, exp_rdy;
  logic [7:0] m_data;
  logic       v[2], l[2], clr[2];
  logic [7:0] d[2];
  int         rem[2];
  vec_t       tbl[8];
  logic [7:0] t3_exp[4];
  logic [1:0] t3_g[4];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 2'b00};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 2'b00};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 2'b00};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 2'b00};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 2'b00};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 2'b01};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 2'b10};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 2'b01};
    t3_exp = '{8'h10, 8'h11, 8'h12, 8'h20};
    t3_g   = '{2'b01, 2'b01, 2'b01, 2'b10};

    bus.tx_busy = 1'b0;
    do_reset();
    smp();
    check("rst_tx_start", bus.tx_start, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_grant", grant, 0);
    check("rst_err", err, 0);
    check("rst_ready", {bus.s1_ready, bus.s0_ready}, 0);

    // Arbitration table from reset (pointer favours s0); valids withdrawn
    // before the edge so nothing is captured.
    for (int i = 0; i < 8; i++) begin
      cyc();
      en = tbl[i].en; bus.s0_valid = tbl[i].v0; bus.s1_valid = tbl[i].v1;
      smp();
      check($sformatf("tbl%0d_ready", i), {bus.s1_ready, bus.s0_ready}, tbl[i].rdy);
      check($sformatf("tbl%0d_grant", i), grant, 0);
      #1;
      bus.s0_valid = 1'b0; bus.s1_valid = 1'b0; en = 1'b1;
    end

    // Single byte: capture->start 1 cycle, ready again after busy + gap.
    do_reset();
    busy_len = 10;
    cyc();
    bus.s0_valid = 1'b1; bus.s0_data = 8'h41; bus.s0_last = 1'b1;
    smp();
    check("t1_ready", {bus.s1_ready, bus.s0_ready}, 2'b01);
    cyc();
    bus.s0_data = 8'h42;
    smp();
    check("t1_start", bus.tx_start, 1);
    check("t1_data", bus.tx_data, 8'h41);
    check("t1_grant", grant, 2'b01);
    check("t1_ready_one_cycle", bus.s0_ready, 0);
    k = 1; cnt = 0;
    while (!bus.s0_ready && k < 40) begin
      cyc(); smp(); k++;
      if (bus.tx_start) cnt++;
    end
    check("t1_ready_latency", k, 3 + 10 + GAP);
    check("t1_single_start", cnt, 0);
    check("t1_data_hold", bus.tx_data, 8'h41);

    // Both valid, single-byte packets: grants alternate.
    do_reset();
    busy_len = 3;
    cyc();
    bus.s0_valid = 1'b1; bus.s0_data = 8'hA0; bus.s0_last = 1'b1;
    bus.s1_valid = 1'b1; bus.s1_data = 8'hB0; bus.s1_last = 1'b1;
    smp();
    for (int j = 0; j < 3; j++) begin
      wait_any(40, k);
      check("t2_order", {bus.s1_ready, bus.s0_ready}, (j % 2 == 0) ? 2'b01 : 2'b10);
      cyc();
      smp();
      check("t2_data", bus.tx_data, (j % 2 == 0) ? 8'hA0 : 8'hB0);
      check("t2_grant", grant, (j % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Packet on s0 stays atomic while s1 waits.
    do_reset();
    busy_len = 2;
    cyc();
    bus.s0_valid = 1'b1; bus.s0_data = 8'h10; bus.s0_last = 1'b0;
    bus.s1_valid = 1'b1; bus.s1_data = 8'h20; bus.s1_last = 1'b1;
    smp();
    for (int j = 0; j < 4; j++) begin
      wait_any(40, k);
      sel = bus.s1_ready;
      cyc();
      if (!sel) begin
        if (bus.s0_data == 8'h12) bus.s0_valid = 1'b0;
        else begin
          bus.s0_data = bus.s0_data + 8'h01;
          bus.s0_last = (bus.s0_data == 8'h12);
        end
      end else bus.s1_valid = 1'b0;
      smp();
      check("t3_start", bus.tx_start, 1);
      check("t3_data", bus.tx_data, t3_exp[j]);
      check("t3_grant", grant, t3_g[j]);
    end

    // Transmitter never acknowledges: sticky timeout, next byte still served.
    do_reset();
    busy_len = 0;
    cyc();
    bus.s1_valid = 1'b1; bus.s1_data = 8'h77; bus.s1_last = 1'b1;
    smp();
    wait_any(10, k);
    cyc();
    bus.s1_valid = 1'b0;
    smp();
    k = 1;
    while (!err && k < 40) begin cyc(); smp(); k++; end
    check("t4_timeout_latency", k, 2 + ACKTO);
    check("t4_grant_cleared", grant, 0);
    busy_len = 4;
    cyc();
    bus.s1_valid = 1'b1; bus.s1_data = 8'h78;
    smp();
    check("t4_next_ready", {bus.s1_ready, bus.s0_ready}, 2'b10);
    cyc();
    bus.s1_valid = 1'b0;
    smp();
    check("t4_next_data", bus.tx_data, 8'h78);
    check("t4_next_start", bus.tx_start, 1);
    for (int j = 0; j < 12; j++) begin cyc(); smp(); end
    check("t4_err_sticky", err, 1);

    // Enable low: in-flight byte completes, no new grant until en returns.
    do_reset();
    busy_len = 5;
    cyc();
    bus.s0_valid = 1'b1; bus.s0_data = 8'h01; bus.s0_last = 1'b1;
    smp();
    wait_any(5, k);
    cyc();
    bus.s0_valid = 1'b0; en = 1'b0;
    bus.s1_valid = 1'b1; bus.s1_data = 8'h33; bus.s1_last = 1'b1;
    smp();
    check("t5_start_with_en_low", bus.tx_start, 1);
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      cyc(); smp();
      if (bus.s0_ready || bus.s1_ready) cnt++;
    end
    check("t5_no_ready_en_low", cnt, 0);
    check("t5_grant_released", grant, 0);
    cyc();
    en = 1'b1;
    smp();
    check("t5_ready_en_high", {bus.s1_ready, bus.s0_ready}, 2'b10);
    cyc();
    bus.s1_valid = 1'b0;
    smp();
    check("t5_data", bus.tx_data, 8'h33);

    // Reset while waiting for the frame to finish.
    do_reset();
    busy_len = 10;
    cyc();
    bus.s0_valid = 1'b1; bus.s0_data = 8'h55; bus.s0_last = 1'b1;
    smp();
    wait_any(5, k);
    cyc(); bus.s0_valid = 1'b0; smp();
    cyc(); smp();
    cyc(); smp();
    cyc(); rst = 1'b1; smp();
    cyc(); rst = 1'b0; smp();
    check("t6_tx_start", bus.tx_start, 0);
    check("t6_tx_data", bus.tx_data, 0);
    check("t6_grant", grant, 0);
    check("t6_err", err, 0);
    check("t6_ready", {bus.s1_ready, bus.s0_ready}, 0);
    cyc();
    bus.s0_valid = 1'b1; bus.s1_valid = 1'b1;
    bus.s0_last = 1'b1; bus.s1_last = 1'b1;
    smp();
    check("t6_pointer_s0", {bus.s1_ready, bus.s0_ready}, 2'b01);

    // Randomized run against a transaction-level model: the scheduler is
    // idle again a fixed number of cycles after each accept, derived from
    // the Tx core busy time, the gap and the acknowledge timeout.
    do_reset();
    now = 0; m_ready_at = 0; m_start_at = -1; m_err_at = 1 << 30;
    m_lock = 1'b0; m_owner = 1'b0; m_rr = 1'b0; m_rel = 1'b0; m_err = 1'b0;
    m_grant = '0; m_data = '0;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; l[i] = 1'b0; d[i] = '0; clr[i] = 1'b0; rem[i] = 0;
    end
    for (int it = 0; it < 3000; it++) begin
      cyc();
      now++;
      for (int i = 0; i < 2; i++) begin
        if (clr[i]) begin v[i] = 1'b0; clr[i] = 1'b0; end
        if (!v[i] && ($urandom % 2 == 0)) begin
          if (rem[i] == 0) rem[i] = int'($urandom_range(1, 3));
          v[i] = 1'b1;
          d[i] = 8'($urandom);
          l[i] = (rem[i] == 1);
        end
      end
      en = ($urandom % 8) != 0;
      bus.s0_valid = v[0]; bus.s0_data = d[0]; bus.s0_last = l[0];
      bus.s1_valid = v[1]; bus.s1_data = d[1]; bus.s1_last = l[1];
      smp();
      if (now == m_ready_at && m_rel) m_grant = 2'b00;
      if (now == m_err_at) m_err = 1'b1;
      exp_rdy = 2'b00;
      if (now >= m_ready_at && en) begin
        if (m_lock) begin
          if (v[m_owner]) exp_rdy = m_owner ? 2'b10 : 2'b01;
        end else if (v[0] && v[1]) exp_rdy = m_rr ? 2'b10 : 2'b01;
        else if (v[0]) exp_rdy = 2'b01;
        else if (v[1]) exp_rdy = 2'b10;
      end
      check("rnd_ready", {bus.s1_ready, bus.s0_ready}, exp_rdy);
      check("rnd_grant", grant, m_grant);
      check("rnd_tx_start", bus.tx_start, 32'(now == m_start_at));
      check("rnd_tx_data", bus.tx_data, m_data);
      check("rnd_err", err, m_err);
      if (exp_rdy != 2'b00) begin
        sel        = exp_rdy[1];
        bl         = ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, 6));
        busy_len   = bl;
        m_data     = d[sel];
        m_start_at = now + 1;
        m_grant    = exp_rdy;
        m_owner    = sel;
        clr[sel]   = 1'b1;
        rem[sel]--;
        if (bl > 0) begin
          m_ready_at = now + 3 + bl + GAP;
          m_rel      = l[sel];
          m_lock     = !l[sel];
          if (l[sel]) m_rr = !sel;
        end else begin
          m_ready_at = now + 2 + ACKTO;
          m_err_at   = m_ready_at;
          m_rel      = 1'b1;
          m_lock     = 1'b0;
          m_rr       = !sel;
        end
      end
    end

    check("never_both_ready", both_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
